// File: rtl/char_sequencer.sv
// Scrolling character sequencer: buffers a short message and shows one character at a time,
// advancing after FRAMES_PER_CHAR vsync frames; pixel output is one register stage behind rom_data.
module char_sequencer #(
  parameter int FRAMES_PER_CHAR = 60,
  parameter int DEPTH           = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vsync,
  input  logic                     display_area,
  input  logic [3:0]               line,
  input  logic                     wr_en,
  input  logic [3:0]               wr_data,
  output logic                     wr_ready,
  input  logic                     clear,
  output logic [7:0]               rom_addr,
  input  logic [7:0]               rom_data,
  output logic                     pixel,
  output logic [$clog2(DEPTH)-1:0] char_index,
  output logic                     busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;
  localparam int FC_W  = (FRAMES_PER_CHAR > 1) ? $clog2(FRAMES_PER_CHAR) : 1;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAMES_PER_CHAR - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW    = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  msg_len_q, msg_len_d;
  logic [IDX_W-1:0]  char_index_q, char_index_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [2:0]        col_q, col_d;
  logic              vsync_d_q, vsync_d_d;
  logic              pixel_q, pixel_d;
  logic              busy_q, busy_d;
  logic [3:0]        msg_q [DEPTH];
  logic [3:0]        msg_d [DEPTH];

  logic              tick;
  logic              wr_acc;
  logic              last_char;

  assign wr_ready  = (msg_len_q != LEN_FULL) && !clear;
  assign wr_acc    = wr_en && wr_ready;
  assign tick      = vsync && !vsync_d_q;
  // Wrap decision always looks at the registered length, so a write landing in ADVANCE cannot extend the current pass.
  assign last_char = ({1'b0, char_index_q} == (msg_len_q - LEN_ONE));

  assign rom_addr   = (state_q == IDLE) ? 8'h00 : {msg_q[char_index_q], line};
  assign pixel      = pixel_q;
  assign busy       = busy_q;
  assign char_index = char_index_q;

  always_comb begin
    state_d      = state_q;
    msg_len_d    = msg_len_q;
    char_index_d = char_index_q;
    frame_cnt_d  = frame_cnt_q;
    msg_d        = msg_q;

    if (wr_acc) begin
      msg_d[msg_len_q[IDX_W-1:0]] = wr_data;
    end

    if (clear) begin
      state_d      = IDLE;
      msg_len_d    = '0;
      char_index_d = '0;
      frame_cnt_d  = '0;
    end else begin
      if (wr_acc) begin
        msg_len_d = msg_len_q + LEN_ONE;
      end
      case (state_q)
        IDLE: begin
          if (msg_len_q != '0) begin
            state_d      = SHOW;
            char_index_d = '0;
            frame_cnt_d  = '0;
          end
        end
        SHOW: begin
          if (tick) begin
            if (frame_cnt_q == FC_LAST) begin
              frame_cnt_d = '0;
              state_d     = ADVANCE;
            end else begin
              frame_cnt_d = frame_cnt_q + FC_ONE;
            end
          end
        end
        ADVANCE: begin
          char_index_d = last_char ? '0 : char_index_q + IDX_ONE;
          state_d      = SHOW;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    vsync_d_d = vsync;
    col_d     = display_area ? col_q + 3'd1 : 3'd0;
    pixel_d   = display_area && rom_data[3'd7 - col_q] && (state_q != IDLE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      msg_len_q    <= '0;
      char_index_q <= '0;
      frame_cnt_q  <= '0;
      col_q        <= 3'd0;
      vsync_d_q    <= 1'b0;
      pixel_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      msg_len_q    <= msg_len_d;
      char_index_q <= char_index_d;
      frame_cnt_q  <= frame_cnt_d;
      col_q        <= col_d;
      vsync_d_q    <= vsync_d_d;
      pixel_q      <= pixel_d;
      busy_q       <= busy_d;
    end
  end

  // Message storage needs no reset: entries past msg_len are never read.
  always_ff @(posedge clk) begin
    msg_q <= msg_d;
  end

endmodule
